// File: rtl/id_scoreboard.sv
// id_scoreboard: GPR pending-write scoreboard and ID->EX issue control.
// Stalls ID on RAW hazards or pending-counter overflow; writeback
// releases entries, flush clears all tracking.
// Ports: clk, rst_n (async low); id_valid/id_ready/id_issue handshake;
// id_r1_*/id_r2_* sources, id_rd_* destination; ex_allowin from EX;
// wb_valid/wb_addr release; flush; inflight_cnt; sticky sb_err.
// Optional macro SB_WB_BYPASS_EN: same-cycle writeback clears a hazard.
module id_scoreboard #(
    parameter int NREG         = 32,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic       id_r1_en,
    input  logic [4:0] id_r1_addr,
    input  logic       id_r2_en,
    input  logic [4:0] id_r2_addr,
    input  logic       id_rd_en,
    input  logic [4:0] id_rd_addr,
    input  logic       ex_allowin,
    output logic       id_issue,
    input  logic       wb_valid,
    input  logic [4:0] wb_addr,
    input  logic       flush,
    output logic [2:0] inflight_cnt,
    output logic       sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [2:0]       INF_MAX = 3'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt   [1:NREG-1];
    logic [CNT_W-1:0] cnt_v [NREG];
    logic [2:0]       inflight;

    logic [CNT_W-1:0] c1, c2, crd, cwb;
    logic             byp1, byp2;
    logic             busy1, busy2, raw, full;
    logic             inc, dec, wb_err;

    // Flat view with r0 pinned to zero so any index is a legal read.
    always_comb begin
        cnt_v[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_v[i] = cnt[i];
        end
    end

    always_comb begin
        c1  = cnt_v[id_r1_addr];
        c2  = cnt_v[id_r2_addr];
        crd = cnt_v[id_rd_addr];
        cwb = cnt_v[wb_addr];
`ifdef SB_WB_BYPASS_EN
        // Last pending write retiring now: regfile write-through
        // supplies the value, so the reader need not wait.
        byp1 = wb_valid && (wb_addr == id_r1_addr) && (c1 == 1);
        byp2 = wb_valid && (wb_addr == id_r2_addr) && (c2 == 1);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        busy1 = (id_r1_addr != 0) && (c1 != 0) && !byp1;
        busy2 = (id_r2_addr != 0) && (c2 != 0) && !byp2;
        raw   = (id_r1_en && busy1) || (id_r2_en && busy2);
        // A saturated destination may still accept if it retires now.
        full  = id_rd_en && (id_rd_addr != 0) &&
                (((crd == CNT_MAX) &&
                  !(wb_valid && (wb_addr == id_rd_addr))) ||
                 ((inflight == INF_MAX) && !wb_valid));
        id_ready = ex_allowin && !raw && !full && !flush;
        id_issue = id_valid && id_ready;
        inc      = id_issue && id_rd_en && (id_rd_addr != 0);
        dec      = wb_valid && (wb_addr != 0) && (cwb != 0);
        wb_err   = wb_valid && (wb_addr != 0) && (cwb == 0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            inflight <= '0;
            sb_err   <= 1'b0;
        end else if (flush) begin
            for (int i = 1; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            inflight <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc && (id_rd_addr == 5'(i)) &&
                    !(dec && (wb_addr == 5'(i)))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dec && (wb_addr == 5'(i)) &&
                             !(inc && (id_rd_addr == 5'(i)))) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (inc && !dec) begin
                inflight <= inflight + 3'd1;
            end else if (dec && !inc) begin
                inflight <= inflight - 3'd1;
            end
            if (wb_err) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign inflight_cnt = inflight;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed plus randomized checks of id_scoreboard
// against a per-register pending-count reference model.
module tb_id_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_ready, id_issue;
    logic       id_r1_en, id_r2_en, id_rd_en;
    logic [4:0] id_r1_addr, id_r2_addr, id_rd_addr;
    logic       ex_allowin, wb_valid, flush;
    logic [4:0] wb_addr;
    logic [2:0] inflight_cnt;
    logic       sb_err;

    int checks   = 0;
    int failures = 0;

    int m_cnt [32];
    int m_infl;
    bit m_err;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    id_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_r1_en     (id_r1_en),
        .id_r1_addr   (id_r1_addr),
        .id_r2_en     (id_r2_en),
        .id_r2_addr   (id_r2_addr),
        .id_rd_en     (id_rd_en),
        .id_rd_addr   (id_rd_addr),
        .ex_allowin   (ex_allowin),
        .id_issue     (id_issue),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .flush        (flush),
        .inflight_cnt (inflight_cnt),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy(input int a);
        bit byp;
        byp = BYP && wb_valid && (int'(wb_addr) == a) && (m_cnt[a] == 1);
        return (a != 0) && (m_cnt[a] != 0) && !byp;
    endfunction

    function automatic bit m_ready();
        bit raw, full;
        int rd;
        rd   = int'(id_rd_addr);
        raw  = (id_r1_en && m_busy(int'(id_r1_addr))) ||
               (id_r2_en && m_busy(int'(id_r2_addr)));
        full = id_rd_en && (rd != 0) &&
               ((m_cnt[rd] == 3 && !(wb_valid && int'(wb_addr) == rd)) ||
                (m_infl == 4 && !wb_valid));
        return ex_allowin && !raw && !full && !flush;
    endfunction

    task automatic m_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_infl = 0;
        m_err  = 1'b0;
    endtask

    task automatic drive(input bit v, input bit r1e, input int r1a,
                         input bit r2e, input int r2a, input bit rde,
                         input int rda, input bit alw, input bit wbv,
                         input int wba, input bit fl);
        id_valid   = v;
        id_r1_en   = r1e;
        id_r1_addr = 5'(r1a);
        id_r2_en   = r2e;
        id_r2_addr = 5'(r2a);
        id_rd_en   = rde;
        id_rd_addr = 5'(rda);
        ex_allowin = alw;
        wb_valid   = wbv;
        wb_addr    = 5'(wba);
        flush      = fl;
    endtask

    // Inputs are set at a negedge; check combinational outputs, then
    // advance the model across the posedge and check the state.
    task automatic cycle();
        bit er, ei;
        int rd, wb;
        #1;
        er = m_ready();
        ei = id_valid && er;
        check("id_ready", int'(id_ready), int'(er));
        check("id_issue", int'(id_issue), int'(ei));
        rd = int'(id_rd_addr);
        wb = int'(wb_addr);
        @(posedge clk);
        if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_infl = 0;
        end else begin
            bit inc, dec;
            inc = ei && id_rd_en && rd != 0;
            dec = wb_valid && wb != 0 && m_cnt[wb] > 0;
            if (wb_valid && wb != 0 && m_cnt[wb] == 0) m_err = 1'b1;
            if (inc) begin m_cnt[rd]++; m_infl++; end
            if (dec) begin m_cnt[wb]--; m_infl--; end
        end
        @(negedge clk);
        check("inflight_cnt", int'(inflight_cnt), m_infl);
        check("sb_err", int'(sb_err), int'(m_err));
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle();
    endtask

    task automatic rand_cycle();
        int w, s;
        bit wbv;
        wbv = 1'b0;
        w   = 0;
        if ($urandom_range(0, 2) == 0) begin
            s = $urandom_range(1, 31);
            for (int k = 0; k < 31; k++) begin
                int a;
                a = ((s + k - 1) % 31) + 1;
                if (!wbv && m_cnt[a] > 0) begin
                    wbv = 1'b1;
                    w   = a;
                end
            end
        end
        drive($urandom_range(0, 3) != 0,
              1'($urandom), $urandom_range(0, 7),
              1'($urandom), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 7),
              $urandom_range(0, 7) != 0, wbv, w,
              $urandom_range(0, 31) == 0);
        cycle();
    endtask

    initial begin
        m_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("rst_ready", int'(id_ready), 0);
        check("rst_issue", int'(id_issue), 0);
        check("rst_inflight", int'(inflight_cnt), 0);
        check("rst_err", int'(sb_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First write issues immediately.
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        #1 check("first_issue", int'(id_issue), 1);
        cycle();
        check("first_inflight", int'(inflight_cnt), 1);

        // RAW on r5 until its writeback.
        drive(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle();
        cycle();
        drive(1, 1, 5, 0, 0, 0, 0, 1, 1, 5, 0);
        #1 check("raw_wb_issue", int'(id_issue), int'(BYP));
        cycle();
        drive(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
        #1 check("raw_after_wb", int'(id_issue), 1);
        cycle();
        check("raw_drained", int'(inflight_cnt), 0);

        // Global in-flight limit.
        for (int r = 1; r <= 4; r++) begin
            drive(1, 0, 0, 0, 0, 1, r, 1, 0, 0, 0);
            cycle();
        end
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        #1 check("limit_stall", int'(id_issue), 0);
        cycle();
        check("limit_cnt", int'(inflight_cnt), 4);
        drive(1, 0, 0, 0, 0, 1, 5, 1, 1, 1, 0);
        #1 check("limit_wb_issue", int'(id_issue), 1);
        cycle();
        check("limit_keep4", int'(inflight_cnt), 4);
        for (int r = 2; r <= 5; r++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 1, r, 0);
            cycle();
        end

        // r0 is never tracked.
        drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        #1 check("r0_issue", int'(id_issue), 1);
        cycle();
        check("r0_inflight", int'(inflight_cnt), 0);

        // Per-register saturation, then flush.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
            cycle();
        end
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        #1 check("sat_stall", int'(id_issue), 0);
        cycle();
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 1);
        cycle();
        check("flush_clear", int'(inflight_cnt), 0);
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        #1 check("post_flush_issue", int'(id_issue), 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0);
        cycle();

        // Spurious writeback sets the sticky error.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0);
        cycle();
        check("err_set", int'(sb_err), 1);

        for (int n = 0; n < 400; n++) rand_cycle();
        check("err_sticky", int'(sb_err), 1);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("arst_err", int'(sb_err), 0);
        check("arst_inflight", int'(inflight_cnt), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        for (int n = 0; n < 400; n++) rand_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
